// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: NCH write-back channels, NSIDE side registers and a valid bit,
// with stall/flush handling and same-address collision resolution. Optional counters: PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
    parameter int unsigned NCH    = 2,
    parameter int unsigned AW     = 5,
    parameter int unsigned DW     = 32,
    parameter int unsigned NSIDE  = 4,
    parameter int unsigned SW     = 64,
    parameter int unsigned STALLW = 6,
    parameter int unsigned STG    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALLW-1:0]     stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [NCH*AW-1:0]     in_wd,
    input  logic [NCH-1:0]        in_wreg,
    input  logic [NCH*DW-1:0]     in_wdata,
    input  logic [NSIDE*SW-1:0]   in_side,
    input  logic                  in_side_we,
    output logic                  out_valid,
    output logic [NCH*AW-1:0]     out_wd,
    output logic [NCH-1:0]        out_wreg,
    output logic [NCH*DW-1:0]     out_wdata,
    output logic [NSIDE*SW-1:0]   out_side,
    output logic                  out_side_we
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]           perf_bubble,
    output logic [31:0]           perf_hold,
    output logic [31:0]           perf_flush
`endif
);

    localparam int unsigned WDW   = NCH * AW;
    localparam int unsigned DATW  = NCH * DW;
    localparam int unsigned SIDEW = NSIDE * SW;
    localparam int unsigned DN    = STG + 1;

    // The downstream stall bit must exist in the stall vector.
    if (DN >= STALLW) begin : g_stg_check
        $error("pipe_stage_reg: STG+1 must be less than STALLW");
    end

    logic             valid_q,   valid_d;
    logic [WDW-1:0]   wd_q,      wd_d;
    logic [NCH-1:0]   wreg_q,    wreg_d;
    logic [DATW-1:0]  wdata_q,   wdata_d;
    logic [SIDEW-1:0] side_q,    side_d;
    logic             side_we_q, side_we_d;

    logic             stall_up_c;
    logic             stall_dn_c;
    logic             take_flush_c;
    logic             take_hold_c;
    logic             take_bubble_c;
    logic             take_capture_c;
    logic [NCH-1:0]   wreg_res_c;
    logic             unused_stall;

    assign stall_up_c   = stall[STG];
    assign stall_dn_c   = stall[DN];
    // Only bits STG and STG+1 matter; the rest of the vector is ignored.
    assign unused_stall = &{1'b0, stall};

    // Branch decode in priority order below reset.
    assign take_flush_c   = flush;
    assign take_hold_c    = !flush && stall_dn_c;
    assign take_bubble_c  = !flush && !stall_dn_c && stall_up_c;
    assign take_capture_c = !flush && !stall_dn_c && !stall_up_c;

    // A channel loses its enable if any higher-index enabled channel targets the same address.
    always_comb begin
        wreg_res_c = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            wreg_res_c[i] = in_wreg[i] & in_valid;
            for (int j = i + 1; j < int'(NCH); j++) begin
                if (in_wreg[j] && (in_wd[j*AW +: AW] == in_wd[i*AW +: AW])) begin
                    wreg_res_c[i] = 1'b0;
                end
            end
        end
    end

    // Next-state: hold by default, bubble on flush or upstream stall, capture otherwise.
    always_comb begin
        valid_d   = valid_q;
        wd_d      = wd_q;
        wreg_d    = wreg_q;
        wdata_d   = wdata_q;
        side_d    = side_q;
        side_we_d = side_we_q;
        if (take_flush_c || take_bubble_c) begin
            valid_d   = 1'b0;
            wd_d      = '0;
            wreg_d    = '0;
            wdata_d   = '0;
            side_d    = '0;
            side_we_d = 1'b0;
        end else if (take_capture_c) begin
            valid_d   = in_valid;
            wd_d      = in_wd;
            wreg_d    = wreg_res_c;
            wdata_d   = in_wdata;
            side_d    = in_side;
            side_we_d = in_side_we & in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            wd_q      <= '0;
            wreg_q    <= '0;
            wdata_q   <= '0;
            side_q    <= '0;
            side_we_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            wd_q      <= wd_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
            side_q    <= side_d;
            side_we_q <= side_we_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_wd      = wd_q;
    assign out_wreg    = wreg_q;
    assign out_wdata   = wdata_q;
    assign out_side    = side_q;
    assign out_side_we = side_we_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] perf_bubble_q;
    logic [31:0] perf_hold_q;
    logic [31:0] perf_flush_q;

    // Cycle counters; a capture of an empty slot counts as a bubble. Wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_bubble_q <= '0;
            perf_hold_q   <= '0;
            perf_flush_q  <= '0;
        end else begin
            if (take_flush_c) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
            if (take_hold_c) begin
                perf_hold_q <= perf_hold_q + 32'd1;
            end
            if (take_bubble_c || (take_capture_c && !in_valid)) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end

    assign perf_bubble = perf_bubble_q;
    assign perf_hold   = perf_hold_q;
    assign perf_flush  = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized traffic
// compared against a per-cycle behavioural model.
module tb_pipe_stage_reg;

    localparam int unsigned NCH    = 2;
    localparam int unsigned AW     = 5;
    localparam int unsigned DW     = 32;
    localparam int unsigned NSIDE  = 4;
    localparam int unsigned SW     = 64;
    localparam int unsigned STALLW = 6;
    localparam int unsigned STG    = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [STALLW-1:0]   stall;
    logic                flush;
    logic                in_valid;
    logic [NCH*AW-1:0]   in_wd;
    logic [NCH-1:0]      in_wreg;
    logic [NCH*DW-1:0]   in_wdata;
    logic [NSIDE*SW-1:0] in_side;
    logic                in_side_we;
    logic                out_valid;
    logic [NCH*AW-1:0]   out_wd;
    logic [NCH-1:0]      out_wreg;
    logic [NCH*DW-1:0]   out_wdata;
    logic [NSIDE*SW-1:0] out_side;
    logic                out_side_we;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]         perf_bubble;
    logic [31:0]         perf_hold;
    logic [31:0]         perf_flush;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .NCH(NCH), .AW(AW), .DW(DW), .NSIDE(NSIDE), .SW(SW), .STALLW(STALLW), .STG(STG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_wd       (in_wd),
        .in_wreg     (in_wreg),
        .in_wdata    (in_wdata),
        .in_side     (in_side),
        .in_side_we  (in_side_we),
        .out_valid   (out_valid),
        .out_wd      (out_wd),
        .out_wreg    (out_wreg),
        .out_wdata   (out_wdata),
        .out_side    (out_side),
        .out_side_we (out_side_we)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .perf_bubble (perf_bubble),
        .perf_hold   (perf_hold),
        .perf_flush  (perf_flush)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the stage contents as plain per-channel arrays.
    logic              m_valid;
    logic [AW-1:0]     m_wd    [NCH];
    logic              m_wreg  [NCH];
    logic [DW-1:0]     m_wdata [NCH];
    logic [SW-1:0]     m_side  [NSIDE];
    logic              m_side_we;
    int unsigned       m_bubble, m_hold, m_flush;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_valid   = 1'b0;
        m_side_we = 1'b0;
        for (int c = 0; c < int'(NCH); c++) begin
            m_wd[c] = '0; m_wreg[c] = 1'b0; m_wdata[c] = '0;
        end
        for (int s = 0; s < int'(NSIDE); s++) m_side[s] = '0;
    endtask

    // Apply one clock's worth of the priority rules to the model from current inputs.
    task automatic model_step();
        if (rst) begin
            model_clear();
            m_bubble = 0; m_hold = 0; m_flush = 0;
        end else if (flush) begin
            model_clear();
            m_flush++;
        end else if (stall[STG+1]) begin
            m_hold++;
        end else if (stall[STG]) begin
            model_clear();
            m_bubble++;
        end else begin
            if (!in_valid) m_bubble++;
            m_valid   = in_valid;
            m_side_we = in_side_we && in_valid;
            for (int c = 0; c < int'(NCH); c++) begin
                m_wd[c]    = in_wd[c*AW +: AW];
                m_wdata[c] = in_wdata[c*DW +: DW];
            end
            for (int c = 0; c < int'(NCH); c++) begin
                bool_chk: begin
                    logic beaten;
                    beaten = 1'b0;
                    for (int k = c + 1; k < int'(NCH); k++)
                        if (in_wreg[k] && m_wd[k] == m_wd[c]) beaten = 1'b1;
                    m_wreg[c] = in_valid && in_wreg[c] && !beaten;
                end
            end
            for (int s = 0; s < int'(NSIDE); s++) m_side[s] = in_side[s*SW +: SW];
        end
    endtask

    task automatic compare_all(input string tag);
        logic [NCH*AW-1:0]   e_wd;
        logic [NCH-1:0]      e_wreg;
        logic [NCH*DW-1:0]   e_wdata;
        logic [NSIDE*SW-1:0] e_side;
        for (int c = 0; c < int'(NCH); c++) begin
            e_wd[c*AW +: AW]    = m_wd[c];
            e_wreg[c]           = m_wreg[c];
            e_wdata[c*DW +: DW] = m_wdata[c];
        end
        for (int s = 0; s < int'(NSIDE); s++) e_side[s*SW +: SW] = m_side[s];
        check_eq({tag, ".valid"},   256'(out_valid),   256'(m_valid));
        check_eq({tag, ".wd"},      256'(out_wd),      256'(e_wd));
        check_eq({tag, ".wreg"},    256'(out_wreg),    256'(e_wreg));
        check_eq({tag, ".wdata"},   256'(out_wdata),   256'(e_wdata));
        check_eq({tag, ".side"},    256'(out_side),    256'(e_side));
        check_eq({tag, ".side_we"}, 256'(out_side_we), 256'(m_side_we));
`ifdef PIPE_STAGE_PERF_EN
        check_eq({tag, ".pbub"},  256'(perf_bubble), 256'(m_bubble));
        check_eq({tag, ".phold"}, 256'(perf_hold),   256'(m_hold));
        check_eq({tag, ".pfl"},   256'(perf_flush),  256'(m_flush));
`endif
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic set_slot(input logic v, input logic [AW-1:0] a1, input logic [AW-1:0] a0,
                            input logic [1:0] we, input logic [DW-1:0] d1, input logic [DW-1:0] d0);
        in_valid = v;
        in_wd    = {a1, a0};
        in_wreg  = we;
        in_wdata = {d1, d0};
    endtask

    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0; in_valid = 1'b0; in_wd = '0;
        in_wreg = '0; in_wdata = '0; in_side = '0; in_side_we = 1'b0;
        model_clear();
        m_bubble = 0; m_hold = 0; m_flush = 0;

        // Reset then capture.
        step("rst0");
        step("rst1");
        check_eq("rst_valid", 256'(out_valid), 256'(0));
        rst = 1'b0;
        set_slot(1'b1, 5'd7, 5'd5, 2'b11, 32'h22, 32'h11);
        step("cap");
        check_eq("cap_wd",   256'(out_wd),   256'({5'd7, 5'd5}));
        check_eq("cap_wreg", 256'(out_wreg), 256'(2'b11));

        // Collision: higher channel wins.
        set_slot(1'b1, 5'd9, 5'd9, 2'b11, 32'hBB, 32'hAA);
        step("coll");
        check_eq("coll_wreg", 256'(out_wreg), 256'(2'b10));
        check_eq("coll_d1",   256'(out_wdata[DW +: DW]), 256'(32'hBB));

        // Bubble versus hold.
        set_slot(1'b1, 5'd0, 5'd3, 2'b01, 32'h0, 32'h1234);
        step("loadA");
        stall = 6'b001000;
        step("bubble");
        check_eq("bubble_valid", 256'(out_valid), 256'(0));
        stall = 6'b000000;
        step("reloadA");
        set_slot(1'b1, 5'd0, 5'd4, 2'b01, 32'h0, 32'h5678);
        stall = 6'b011000;
        for (int k = 0; k < 3; k++) begin
            step("hold");
            check_eq("hold_wd", 256'(out_wd), 256'({5'd0, 5'd3}));
        end
        stall = 6'b000000;
        step("release");
        check_eq("release_wd", 256'(out_wd), 256'({5'd0, 5'd4}));

        // Flush overrides hold; hold then keeps the zeroed slot.
        stall = 6'b010000;
        flush = 1'b1;
        step("flush");
        check_eq("flush_wdata", 256'(out_wdata), 256'(0));
        flush = 1'b0;
        step("post_flush_hold");

        // Side register path.
        stall = '0;
        in_side = {64'h1, 64'h2, 64'h3, 64'h4};
        in_side_we = 1'b1;
        in_valid = 1'b0;
        step("side_inv");
        check_eq("side_val", 256'(out_side), 256'({64'h1, 64'h2, 64'h3, 64'h4}));
        check_eq("side_we0", 256'(out_side_we), 256'(0));
        in_valid = 1'b1;
        step("side_v");
        check_eq("side_we1", 256'(out_side_we), 256'(1));

        // Counter scenario: 4 holds, 2 bubbles, 1 flush from reset.
        rst = 1'b1;
        step("prst");
        rst = 1'b0;
        stall = 6'b010000;
        for (int k = 0; k < 4; k++) step("phold");
        stall = 6'b001000;
        for (int k = 0; k < 2; k++) step("pbub");
        stall = '0;
        flush = 1'b1;
        step("pflush");
        flush = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
        check_eq("perf_hold4",   256'(perf_hold),   256'(4));
        check_eq("perf_bubble2", 256'(perf_bubble), 256'(2));
        check_eq("perf_flush1",  256'(perf_flush),  256'(1));
`endif
        rst = 1'b1;
        step("prst2");
        rst = 1'b0;

        // Randomized traffic; narrow address range to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 99) < 2);
            flush      = ($urandom_range(0, 99) < 6);
            for (int b = 0; b < int'(STALLW); b++) stall[b] = ($urandom_range(0, 3) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_wd      = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
            in_wreg    = 2'($urandom);
            in_wdata   = {32'($urandom), 32'($urandom)};
            in_side    = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom),
                          32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            in_side_we = 1'($urandom);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for the dcpu core.
- Generalises the single-port MEM/WB latch to NCH write-back channels, NSIDE wide side registers (descriptor-table class) and a valid bit.
- Stall handling is correct: the stage holds its contents when the downstream stage stalls, instead of clearing them.
- Resolves same-address write collisions between channels at capture. Instantiated at any stage boundary; STG selects the stall-vector bit it obeys.

Parameters:
- NCH, 2, number of register write-back channels (1..4)
- AW, 5, register address width per channel
- DW, 32, write data width per channel
- NSIDE, 4, number of side registers (idt/gdt/ldt/tr order at default)
- SW, 64, side register width
- STALLW, 6, stall vector width
- STG, 3, index of upstream-stage stall bit; STG+1 is the downstream bit; STG+1 < STALLW is required (elaboration error otherwise)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset (RstEnable = 1)
- stall  in  STALLW  pipeline stall vector
- flush  in  1  pipeline flush
- in_valid  in  1  upstream slot carries an instruction
- in_wd  in  NCH*AW  write addresses, channel c at [c*AW +: AW]
- in_wreg  in  NCH  per-channel write enable
- in_wdata  in  NCH*DW  per-channel write data
- in_side  in  NSIDE*SW  side register values
- in_side_we  in  1  side-register write enable
- out_valid  out  1  registered valid
- out_wd  out  NCH*AW  registered addresses
- out_wreg  out  NCH  registered, collision-resolved write enables
- out_wdata  out  NCH*DW  registered data
- out_side  out  NSIDE*SW  registered side values
- out_side_we  out  1  registered side write enable

Behaviour:
- All outputs are registered on posedge clk. No combinational path from input to output. Latency 1 cycle.
- Reset and bubble value for all outputs: 0. Addresses use NOPRegAddr (0), enables use WriteDisable, data uses ZeroWord/ZeroDWord, out_valid = 0.
- Per-cycle priority, highest first:
  1. rst: load reset value.
  2. flush: load bubble. Flush overrides a downstream stall.
  3. stall[STG+1]==Stop: hold all outputs unchanged, regardless of stall[STG].
  4. stall[STG]==Stop (with stall[STG+1]==NoStop): load bubble.
  5. Otherwise: capture inputs.
- Capture rules:
  - out_valid <= in_valid.
  - If in_valid==0, every enable is loaded as 0. Addresses and data are still captured.
  - Collision resolution: if channels i<j both have in_wreg set and equal in_wd, out_wreg[i] is 0. The highest-index channel wins.
  - A channel with in_wreg set and in_wd==0 keeps its enable. Register-0 filtering belongs to the register file.
  - out_side_we <= in_side_we & in_valid. out_side is captured unconditionally on capture.
- Stall bits with index other than STG and STG+1 are ignored.
- Reset or flush asserted during a hold: takes effect on that edge. The held contents are discarded.
- Bits beyond the defined stall vector are don't-care.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined, adds the following, each reset to 0 only by rst:
  - Output ports perf_bubble, perf_hold, perf_flush, each 32-bit.
  - perf_bubble counts cycles taking branch 4, or branch 5 with in_valid==0.
  - perf_hold counts cycles taking branch 3.
  - perf_flush counts cycles taking branch 2.
  - Counters wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset then capture: rst=1 for 2 cycles, then in_valid=1, in_wd ch0=5, ch1=7, in_wreg=2'b11, in_wdata=0x11/0x22, stall=0 -> after reset all outputs are 0; 1 cycle after capture out_wd={7,5}, out_wreg=2'b11, out_valid=1.
- Collision: ch0 and ch1 both address 9, in_wreg=2'b11, data 0xAA/0xBB -> out_wreg=2'b10, out_wdata ch1=0xBB.
- Bubble vs hold: load slot A (wd=3, data 0x1234); then stall=6'b001000 -> bubble (out_valid=0, out_wreg=0). Reload A, then stall=6'b011000 for 3 cycles -> outputs stay A with out_valid=1; release -> next input captured.
- Flush over hold: stall=6'b010000 holding slot A, flush=1 for 1 cycle -> next edge outputs are 0. Hold then resumes on the zeroed contents.
- Side path: in_side = {0x1,0x2,0x3,0x4} (64-bit each), in_side_we=1, in_valid=0 -> out_side captured, out_side_we=0. Same with in_valid=1 -> out_side_we=1.
- PIPE_STAGE_PERF_EN: 4 hold cycles, 2 bubble cycles, 1 flush -> perf_hold=4, perf_bubble=2, perf_flush=1. Then rst -> all counters 0.
